// File: rtl/rca_pipe_pkg.sv
// rca_pipe_pkg: shared parameter checks for the pipelined ripple-carry adder
package rca_pipe_pkg;
   function automatic bit params_ok(input int width, input int stages);
      return stages >= 1 && width >= 1 && width % stages == 0;
   endfunction
endpackage

// File: rtl/rca_pipe_add_chunk.sv
// add_chunk: combinational W-bit ripple-carry adder for one pipeline chunk
// ports: a, b, c (carry in) -> sum, carry (out of MSB), cmsb (carry into MSB)
module add_chunk
   import rca_pipe_pkg::*;
#(
   parameter int W = 4
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         c,
   output logic [W-1:0] sum,
   output logic         carry,
   output logic         cmsb
);
   logic [W:0] cc;
   always_comb begin
      cc[0] = c;
      for (int i = 0; i < W; i++) begin
         sum[i]  = a[i] ^ b[i] ^ cc[i];
         cc[i+1] = (a[i] & b[i]) | (cc[i] & (a[i] ^ b[i]));
      end
   end
   assign carry = cc[W];
   assign cmsb  = cc[W-1];
endmodule

// File: rtl/rca_pipe.sv
// rca_pipe: pipelined ripple-carry adder/subtractor, one CHUNK-bit ripple per stage
// ports: clk, rst (sync, active-high); in_valid/in_ready with a, b, cin, sub;
//        out_valid/out_ready with sum, cout, ovf, zero (all registered)
module rca_pipe
   import rca_pipe_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);
   localparam int CHUNK = WIDTH / STAGES;
   if (!params_ok(WIDTH, STAGES)) begin : g_bad
      $error("rca_pipe: WIDTH must be a positive multiple of STAGES >= 1");
   end
   logic             advance;
   logic [WIDTH-1:0] bx;
   assign advance  = !out_valid || out_ready;
   assign in_ready = advance;
   assign bx       = b ^ {WIDTH{sub}};
   // stage k: ra/rb hold operand bits from chunk k upward, qs holds the finished low sum chunks
   for (genvar k = 0; k < STAGES; k++) begin : stg
      logic [WIDTH-k*CHUNK-1:0] ra, rb;
      logic [CHUNK-1:0]         cs;
      logic [(k+1)*CHUNK-1:0]   ns, qs;
      logic                     ci, co, iv, qc, qv;
      if (k == 0) begin : g_src
         assign ra = a;
         assign rb = bx;
         assign ci = cin ^ sub;
         assign iv = in_valid;
         assign ns = cs;
      end else begin : g_src
         assign ra = stg[k-1].g_mid.qa;
         assign rb = stg[k-1].g_mid.qb;
         assign ci = stg[k-1].qc;
         assign iv = stg[k-1].qv;
         assign ns = {cs, stg[k-1].qs};
      end
      always_ff @(posedge clk)
         if (rst) begin
            qv <= 1'b0;
            qc <= 1'b0;
            qs <= '0;
         end else if (advance) begin
            qv <= iv;
            qc <= co;
            qs <= ns;
         end
      if (k == STAGES - 1) begin : g_fin
         logic cm, qo, qz;
         add_chunk #(.W(CHUNK)) u_add (.a(ra[CHUNK-1:0]), .b(rb[CHUNK-1:0]), .c(ci), .sum(cs), .carry(co), .cmsb(cm));
         // flags are registered alongside the last chunk so the output port is pure register
         always_ff @(posedge clk)
            if (rst) begin
               qo <= 1'b0;
               qz <= 1'b0;
            end else if (advance) begin
               qo <= cm ^ co;
               qz <= ns == '0;
            end
      end else begin : g_mid
         logic [WIDTH-(k+1)*CHUNK-1:0] qa, qb;
         add_chunk #(.W(CHUNK)) u_add (.a(ra[CHUNK-1:0]), .b(rb[CHUNK-1:0]), .c(ci), .sum(cs), .carry(co), .cmsb());
         always_ff @(posedge clk)
            if (advance) begin
               qa <= ra[WIDTH-k*CHUNK-1:CHUNK];
               qb <= rb[WIDTH-k*CHUNK-1:CHUNK];
            end
      end
   end
   assign out_valid = stg[STAGES-1].qv;
   assign sum       = stg[STAGES-1].qs;
   assign cout      = stg[STAGES-1].qc;
   assign ovf       = stg[STAGES-1].g_fin.qo;
   assign zero      = stg[STAGES-1].g_fin.qz;
endmodule
